// File: rtl/mux_n_1_scan.sv
// ============================================================================
// Module   : mux_n_1_scan
// Brief    : Registered CH_NUM:1 mux with manual select and auto-scan rotation.
//            Optional macro MUX_CH_MASK_EN adds a ch_mask port for skipping channels.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_n_1_scan #(
   parameter  int CH_NUM = 4,
   parameter  int DATA_W = 8,
   parameter  int DWELL  = 10,
   localparam int SEL_W  = (CH_NUM > 2) ? $clog2(CH_NUM) : 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic [CH_NUM*DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]         sel,
   input  logic                     mode,
`ifdef MUX_CH_MASK_EN
   input  logic [CH_NUM-1:0]        ch_mask,
`endif
   output logic [DATA_W-1:0]        out,
   output logic [SEL_W-1:0]         out_ch,
   output logic                     out_valid,
   output logic                     scan_wrap
);

   localparam int                DW_W       = $clog2(DWELL) + 1;
   localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic [0:0] {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } state_t;

   state_t              state, next_state;
   logic [SEL_W-1:0]    ptr, next_ptr;
   logic [DW_W-1:0]     dwell_cnt, next_dwell;
   logic [DATA_W-1:0]   next_out;
   logic [SEL_W-1:0]    next_ch;
   logic                next_valid;
   logic                next_wrap;

   logic [CH_NUM-1:0]   en;
   logic                any_en;
   logic                sel_ok;
   logic [DATA_W-1:0]   man_out;
   logic [SEL_W-1:0]    first_idx;
   logic [SEL_W-1:0]    adv_idx;
   logic                adv_wrap;

`ifdef MUX_CH_MASK_EN
   assign en = ch_mask;
`else
   assign en = '1;
`endif

   function automatic logic [DATA_W-1:0] chan(input logic [CH_NUM*DATA_W-1:0] d,
                                              input logic [SEL_W-1:0]         idx);
      chan = '0;
      for (int k = 0; k < CH_NUM; k++)
         if (int'(idx) == k) chan = d[k*DATA_W +: DATA_W];
   endfunction

   assign any_en  = |en;
   assign sel_ok  = (int'(sel) < CH_NUM) && en[sel];
   assign man_out = sel_ok ? chan(in_data, sel) : '0;

   // Lowest enabled index for scan entry, and the next enabled index after ptr.
   // Descending loops let the nearest candidate win by being assigned last.
   always_comb begin
      first_idx = '0;
      adv_idx   = ptr;
      adv_wrap  = 1'b0;
      for (int k = CH_NUM - 1; k >= 0; k--)
         if (en[k]) first_idx = SEL_W'(k);
      for (int k = CH_NUM; k >= 1; k--) begin
         if (en[(int'(ptr) + k) % CH_NUM]) begin
            adv_idx  = SEL_W'((int'(ptr) + k) % CH_NUM);
            adv_wrap = (int'(ptr) + k) >= CH_NUM;
         end
      end
   end

   always_comb begin
      next_state = state;
      next_ptr   = ptr;
      next_dwell = dwell_cnt;
      next_out   = out;
      next_ch    = out_ch;
      next_valid = out_valid;
      next_wrap  = 1'b0;
      case (state)
         MANUAL: begin
            if (mode) begin
               next_state = AUTO;
               next_ptr   = first_idx;
               next_dwell = '0;
               next_out   = any_en ? chan(in_data, first_idx) : '0;
               next_ch    = first_idx;
               next_valid = any_en;
            end else begin
               next_ptr   = '0;
               next_dwell = '0;
               next_out   = man_out;
               next_ch    = sel;
               next_valid = sel_ok;
            end
         end
         AUTO: begin
            if (!mode) begin
               next_state = MANUAL;
               next_ptr   = '0;
               next_dwell = '0;
               next_out   = man_out;
               next_ch    = sel;
               next_valid = sel_ok;
            end else if (!any_en) begin
               next_dwell = '0;
               next_out   = '0;
               next_ch    = ptr;
               next_valid = 1'b0;
            end else if (dwell_cnt == DWELL_LAST || !en[ptr]) begin
               // A channel disabled mid-dwell is abandoned immediately.
               next_dwell = '0;
               next_ptr   = adv_idx;
               next_wrap  = adv_wrap;
               next_out   = chan(in_data, adv_idx);
               next_ch    = adv_idx;
               next_valid = 1'b1;
            end else begin
               next_dwell = dwell_cnt + DW_W'(1);
               next_out   = chan(in_data, ptr);
               next_ch    = ptr;
               next_valid = 1'b1;
            end
         end
         default: next_state = MANUAL;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= MANUAL;
         ptr       <= '0;
         dwell_cnt <= '0;
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         scan_wrap <= 1'b0;
      end else begin
         state     <= next_state;
         ptr       <= next_ptr;
         dwell_cnt <= next_dwell;
         out       <= next_out;
         out_ch    <= next_ch;
         out_valid <= next_valid;
         scan_wrap <= next_wrap;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mux_n_1_scan.sv
// ============================================================================
// Module   : tb_mux_n_1_scan
// Brief    : Vector-table bench for mux_n_1_scan (4-ch/DWELL=3 and 3-ch/DWELL=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_n_1_scan;

   logic        clk;
   logic        rst_n;

   logic [31:0] din4;
   logic [1:0]  sel4;
   logic        mode4;
   logic [7:0]  out4;
   logic [1:0]  ch4;
   logic        valid4;
   logic        wrap4;

   logic [23:0] din3;
   logic [1:0]  sel3;
   logic        mode3;
   logic [7:0]  out3;
   logic [1:0]  ch3;
   logic        valid3;
   logic        wrap3;

`ifdef MUX_CH_MASK_EN
   logic [3:0]  mask4;
   logic [2:0]  mask3;
`endif

   int tests = 0;
   int fails = 0;

   mux_n_1_scan #(.CH_NUM(4), .DATA_W(8), .DWELL(3)) dut4 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in_data   (din4),
      .sel       (sel4),
      .mode      (mode4),
`ifdef MUX_CH_MASK_EN
      .ch_mask   (mask4),
`endif
      .out       (out4),
      .out_ch    (ch4),
      .out_valid (valid4),
      .scan_wrap (wrap4)
   );

   mux_n_1_scan #(.CH_NUM(3), .DATA_W(8), .DWELL(2)) dut3 (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .in_data   (din3),
      .sel       (sel3),
      .mode      (mode3),
`ifdef MUX_CH_MASK_EN
      .ch_mask   (mask3),
`endif
      .out       (out3),
      .out_ch    (ch3),
      .out_valid (valid3),
      .scan_wrap (wrap3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [1:0]  sel;
      logic [31:0] din;
      logic [7:0]  e_out;
      logic [1:0]  e_ch;
      logic        e_valid;
      logic        e_wrap;
   } vec_t;

   function automatic vec_t mk(logic m, logic [1:0] s, logic [31:0] d,
                               logic [7:0] eo, logic [1:0] ec, logic ev, logic ew);
      vec_t v;
      v.mode = m; v.sel = s; v.din = d;
      v.e_out = eo; v.e_ch = ec; v.e_valid = ev; v.e_wrap = ew;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check4(input string tag, input logic [7:0] eo, input logic [1:0] ec,
                         input logic ev, input logic ew);
      check({tag, " out"},   32'(out4),   32'(eo));
      check({tag, " ch"},    32'(ch4),    32'(ec));
      check({tag, " valid"}, 32'(valid4), 32'(ev));
      check({tag, " wrap"},  32'(wrap4),  32'(ew));
   endtask

   localparam logic [31:0] D  = 32'hDDCC_BBAA;
   localparam logic [31:0] D2 = 32'hDDCC_BB5A;

   vec_t vecs[27];

   initial begin
      // Manual selects, then a full auto scan, a mid-scan exit and a re-entry.
      vecs[0]  = mk(0, 2, D,  8'hCC, 2, 1, 0);
      vecs[1]  = mk(0, 0, D,  8'hAA, 0, 1, 0);
      vecs[2]  = mk(0, 3, D,  8'hDD, 3, 1, 0);
      vecs[3]  = mk(0, 1, D,  8'hBB, 1, 1, 0);
      for (int i = 4;  i <= 6;  i++) vecs[i] = mk(1, 1, D, 8'hAA, 0, 1, 0);
      for (int i = 7;  i <= 9;  i++) vecs[i] = mk(1, 1, D, 8'hBB, 1, 1, 0);
      for (int i = 10; i <= 12; i++) vecs[i] = mk(1, 1, D, 8'hCC, 2, 1, 0);
      for (int i = 13; i <= 15; i++) vecs[i] = mk(1, 1, D, 8'hDD, 3, 1, 0);
      vecs[16] = mk(1, 1, D,  8'hAA, 0, 1, 1);
      vecs[17] = mk(1, 1, D,  8'hAA, 0, 1, 0);
      vecs[18] = mk(1, 1, D,  8'hAA, 0, 1, 0);
      for (int i = 19; i <= 21; i++) vecs[i] = mk(1, 1, D, 8'hBB, 1, 1, 0);
      vecs[22] = mk(1, 1, D,  8'hCC, 2, 1, 0);
      vecs[23] = mk(1, 1, D,  8'hCC, 2, 1, 0);
      vecs[24] = mk(0, 1, D,  8'hBB, 1, 1, 0);
      vecs[25] = mk(1, 1, D,  8'hAA, 0, 1, 0);
      vecs[26] = mk(1, 1, D2, 8'h5A, 0, 1, 0);

      rst_n = 1'b0;
      din4 = D; sel4 = '0; mode4 = 1'b0;
      din3 = 24'h332211; sel3 = '0; mode3 = 1'b0;
`ifdef MUX_CH_MASK_EN
      mask4 = 4'hF;
      mask3 = 3'h7;
`endif

      for (int c = 0; c < 3; c++) begin
         din4 = $urandom; sel4 = 2'($urandom); mode4 = 1'($urandom);
         din3 = 24'($urandom); sel3 = 2'($urandom); mode3 = 1'($urandom);
         tick();
         check4($sformatf("reset%0d", c), 8'h00, 2'd0, 1'b0, 1'b0);
         check($sformatf("reset%0d out3", c),   32'(out3),   32'd0);
         check($sformatf("reset%0d valid3", c), 32'(valid3), 32'd0);
      end
      mode4 = 1'b0; mode3 = 1'b0; sel3 = 2'd0;
      rst_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         mode4 = vecs[i].mode;
         sel4  = vecs[i].sel;
         din4  = vecs[i].din;
         tick();
         check4($sformatf("row%0d", i), vecs[i].e_out, vecs[i].e_ch,
                vecs[i].e_valid, vecs[i].e_wrap);
      end

      // Async reset mid-scan must clear outputs before any clock edge.
      #2 rst_n = 1'b0;
      #1 check4("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b1;
      din4 = D; mode4 = 1'b0; sel4 = 2'd2;
      tick();
      check4("post_rst", 8'hCC, 2'd2, 1'b1, 1'b0);

      // Three-channel instance: out-of-range select, then a DWELL=2 scan.
      sel3 = 2'd3; mode3 = 1'b0; din3 = 24'h332211;
      tick();
      check("oor out3",   32'(out3),   32'd0);
      check("oor ch3",    32'(ch3),    32'd3);
      check("oor valid3", 32'(valid3), 32'd0);
      sel3 = 2'd2;
      tick();
      check("sel2 out3",   32'(out3),   32'h33);
      check("sel2 valid3", 32'(valid3), 32'd1);
      mode3 = 1'b1;
      begin
         automatic int exp_ch3[7] = '{0, 0, 1, 1, 2, 2, 0};
         for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("scan3_%0d ch", i),   32'(ch3),   32'(exp_ch3[i]));
            check($sformatf("scan3_%0d out", i),  32'(out3),  32'h11 * 32'(exp_ch3[i] + 1));
            check($sformatf("scan3_%0d wrap", i), 32'(wrap3), (i == 6) ? 32'd1 : 32'd0);
         end
      end
      mode3 = 1'b0;

`ifdef MUX_CH_MASK_EN
      // Channels 1 and 3 only; scan_wrap marks the pass through index 0.
      mask4 = 4'b1010; mode4 = 1'b1; din4 = D;
      begin
         automatic int exp_m[7] = '{1, 1, 1, 3, 3, 3, 1};
         for (int i = 0; i < 7; i++) begin
            tick();
            check4($sformatf("mask%0d", i), (exp_m[i] == 1) ? 8'hBB : 8'hDD,
                   2'(exp_m[i]), 1'b1, (i == 6) ? 1'b1 : 1'b0);
         end
      end
      mask4 = 4'b0000;
      tick();
      check("mask0 out",   32'(out4),   32'd0);
      check("mask0 valid", 32'(valid4), 32'd0);
      check("mask0 wrap",  32'(wrap4),  32'd0);
      mode4 = 1'b0; sel4 = 2'd1;
      tick();
      check("mask0 manual valid", 32'(valid4), 32'd0);
      mask4 = 4'hF;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
